// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state type, timer type and constants for the UART receive path
package uart_pkg;

    localparam int TIMER_W_DFLT = 16;

    typedef logic [TIMER_W_DFLT-1:0] timer_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        PARITY
    } rx_state_t;

    localparam logic   TRUE    = 1'b1;
    localparam logic   FALSE   = 1'b0;
    localparam timer_t MIN_DIV = timer_t'(2);

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchronizer for the RX pin, resets to the idle-high level
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_s1;
    logic r_s2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1 <= TRUE;
            r_s2 <= TRUE;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end

    assign o_q = r_s2;

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receiver: mid-bit sampling FSM with valid/ready byte output
// Optional parity stage enabled by defining UART_PARITY_EN.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int TIMER_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [TIMER_W-1:0] baud_div,
    input  logic               rx,
`ifdef UART_PARITY_EN
    input  logic               parity_odd,
    output logic               parity_err,
`endif
    output logic [DATA_W-1:0]  data_out,
    output logic               data_valid,
    input  logic               data_ready,
    output logic               busy,
    output logic               frame_err,
    output logic               overrun_err
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    rx_state_t          r_state;
    rx_state_t          w_state_nxt;
    logic [TIMER_W-1:0] r_timer;
    logic [TIMER_W-1:0] r_div;
    logic [TIMER_W-1:0] w_limit;
    logic               w_tick;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic [DATA_W-1:0]  r_shift;
    logic [DATA_W-1:0]  r_data;
    logic               r_valid;
    logic               r_busy;
    logic               r_ferr;
    logic               r_ovr;
    logic               w_rx_s;
    logic               w_shift_en;
    logic               w_accept;
    logic               w_ferr;
    logic               w_handshake;
`ifdef UART_PARITY_EN
    logic               r_par_bit;
    logic               r_perr;
    logic               w_perr;
    logic               w_par_bad;
`endif

    uart_rx_sync u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (rx),
        .o_q (w_rx_s)
    );

    // START waits half a bit so every later tick lands on a bit centre.
    assign w_limit = (r_state == START) ? (r_div >> 1) : r_div;
    assign w_tick  = (r_state != IDLE) && (r_timer == w_limit - TIMER_W'(1));

`ifdef UART_PARITY_EN
    assign w_par_bad = ((^r_shift) ^ r_par_bit) != parity_odd;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_shift_en  = FALSE;
        w_accept    = FALSE;
        w_ferr      = FALSE;
`ifdef UART_PARITY_EN
        w_perr      = FALSE;
`endif
        case (r_state)
            IDLE: begin
                if (!w_rx_s) begin
                    w_state_nxt = START;
                end
            end
            START: begin
                if (w_tick) begin
                    w_state_nxt = w_rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (w_tick) begin
                    w_shift_en = TRUE;
                    if (r_bit_cnt == CNT_W'(DATA_W - 1)) begin
`ifdef UART_PARITY_EN
                        w_state_nxt = PARITY;
`else
                        w_state_nxt = STOP;
`endif
                    end
                end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
                if (w_tick) begin
                    w_state_nxt = STOP;
                end
            end
`endif
            STOP: begin
                if (w_tick) begin
                    w_state_nxt = IDLE;
                    if (!w_rx_s) begin
                        w_ferr = TRUE;
`ifdef UART_PARITY_EN
                    end else if (w_par_bad) begin
                        w_perr = TRUE;
`endif
                    end else begin
                        w_accept = TRUE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        // A disabled receiver drops any partial frame without raising flags.
        if (!enable) begin
            w_state_nxt = IDLE;
            w_shift_en  = FALSE;
            w_accept    = FALSE;
            w_ferr      = FALSE;
`ifdef UART_PARITY_EN
            w_perr      = FALSE;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_busy  <= FALSE;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_timer <= '0;
        end else if ((w_state_nxt != r_state) || (r_state == IDLE) || w_tick) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + TIMER_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div <= TIMER_W'(MIN_DIV);
        end else if ((r_state == IDLE) && (w_state_nxt == START)) begin
            r_div <= (baud_div < TIMER_W'(MIN_DIV)) ? TIMER_W'(MIN_DIV) : baud_div;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else begin
            if (r_state == START) begin
                r_bit_cnt <= '0;
            end else if (w_shift_en) begin
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
            if (w_shift_en) begin
                r_shift <= {w_rx_s, r_shift[DATA_W-1:1]};
            end
        end
    end

`ifdef UART_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_par_bit <= FALSE;
            r_perr    <= FALSE;
        end else begin
            if ((r_state == PARITY) && w_tick) begin
                r_par_bit <= w_rx_s;
            end
            r_perr <= w_perr;
        end
    end

    assign parity_err = r_perr;
`endif

    assign w_handshake = r_valid & data_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data  <= '0;
            r_valid <= FALSE;
            r_ferr  <= FALSE;
            r_ovr   <= FALSE;
        end else begin
            r_ferr <= w_ferr;
            r_ovr  <= FALSE;
            if (w_accept) begin
                if (!r_valid || w_handshake) begin
                    r_data  <= r_shift;
                    r_valid <= TRUE;
                end else begin
                    r_ovr <= TRUE;
                end
            end else if (w_handshake) begin
                r_valid <= FALSE;
            end
        end
    end

    assign data_out    = r_data;
    assign data_valid  = r_valid;
    assign busy        = r_busy;
    assign frame_err   = r_ferr;
    assign overrun_err = r_ovr;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - directed frames against a byte-queue model of the UART receiver
`timescale 1ns/1ps
module tb_uart_rx_ctrl;

    localparam int DW = 8;
    localparam int TW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          enable = 1'b0;
    logic [TW-1:0] baud_div = 16'd16;
    logic          rx = 1'b1;
    logic          data_ready = 1'b1;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          busy;
    logic          frame_err;
    logic          overrun_err;
`ifdef UART_PARITY_EN
    logic          parity_odd = 1'b0;
    logic          parity_err;
`endif

    int  checks = 0;
    int  errors = 0;

    logic [7:0] q_exp[$];
    logic [7:0] cur = '0;
    logic [7:0] last_byte = '0;
    bit         have_cur = 0;
    bit         mon_on = 0;
    int         n_rise = 0, n_ferr = 0, n_ovr = 0, n_perr = 0, run_len = 0;
    int         exp_ferr = 0, exp_ovr = 0, exp_perr = 0;
    time        fall_t = 0, rise_t = 0;

    always #5 clk = ~clk;

    uart_rx_ctrl #(.DATA_W(DW), .TIMER_W(TW)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .baud_div    (baud_div),
        .rx          (rx),
`ifdef UART_PARITY_EN
        .parity_odd  (parity_odd),
        .parity_err  (parity_err),
`endif
        .data_out    (data_out),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .busy        (busy),
        .frame_err   (frame_err),
        .overrun_err (overrun_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Outcome of a frame is decided from its content and whether a byte is still unconsumed.
    task automatic predict(input logic [7:0] b, input logic stop, input logic par);
        if (!stop) begin
            exp_ferr++;
`ifdef UART_PARITY_EN
        end else if (((^b) ^ par) != parity_odd) begin
            exp_perr++;
`endif
        end else if ((have_cur || q_exp.size() > 0) && !data_ready) begin
            exp_ovr++;
        end else begin
            q_exp.push_back(b);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic stop, input int nbits, input logic par);
        int d;
        d = (baud_div < 2) ? 2 : int'(baud_div);
        @(posedge clk);
        rx = 1'b0;
        fall_t = $time;
        repeat (d) @(posedge clk);
        for (int i = 0; i < 8 && i < nbits; i++) begin
            rx = b[i];
            repeat (d) @(posedge clk);
        end
        if (nbits < 8) begin
            rx = 1'b1;
            return;
        end
`ifdef UART_PARITY_EN
        rx = par;
        repeat (d) @(posedge clk);
`endif
        predict(b, stop, par);
        rx = stop;
        repeat (d) @(posedge clk);
        rx = 1'b1;
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            if (frame_err) n_ferr++;
            if (overrun_err) n_ovr++;
`ifdef UART_PARITY_EN
            if (parity_err) n_perr++;
            if (frame_err | overrun_err | parity_err)
                chk("flags_exclusive", 32'(frame_err) + 32'(overrun_err) + 32'(parity_err), 1);
`else
            if (frame_err | overrun_err)
                chk("flags_exclusive", 32'(frame_err) + 32'(overrun_err), 1);
`endif
            if (data_valid) begin
                if (!have_cur) begin
                    if (q_exp.size() == 0) begin
                        chk("unexpected_valid", data_valid, 0);
                        cur = data_out;
                    end else begin
                        cur = q_exp.pop_front();
                    end
                    n_rise++;
                    rise_t = $time;
                    last_byte = data_out;
                    run_len = 0;
                end
                chk("data_out", data_out, cur);
                run_len++;
                have_cur = !data_ready;
            end else begin
                if (have_cur) chk("valid_held", data_valid, 1);
                have_cur = 0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        longint lat;
        int     n;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data_out", data_out, 0);
        chk("rst_data_valid", data_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_overrun_err", overrun_err, 0);
        @(posedge clk);
        rst = 1'b1;
        enable = 1'b1;
        mon_on = 1;
        repeat (20) @(posedge clk);

        send(8'hA5, 1'b1, 8, ^8'hA5);
        repeat (40) @(posedge clk);
        #1;
        chk("t1_rises", n_rise, 1);
        chk("t1_byte", last_byte, 8'hA5);
        chk("t1_valid_cycles", run_len, 1);
        chk("t1_frame_err", n_ferr, 0);
        lat = (rise_t - fall_t) / 10;
        checks++;
        if (lat < 152 || lat > 156) begin
            errors++;
            $display("FAIL t1_latency actual=%0d required=152..156", lat);
        end

        @(posedge clk);
        rx = 1'b0;
        repeat (4) @(posedge clk);
        rx = 1'b1;
        #1;
        chk("t2_busy_high", busy, 1);
        n = 0;
        while (busy && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("t2_busy_fall", busy, 0);
        repeat (20) @(posedge clk);
        chk("t2_rises", n_rise, 1);
        chk("t2_ferr", n_ferr, 0);
        chk("t2_ovr", n_ovr, 0);

        send(8'h3C, 1'b0, 8, ^8'h3C);
        repeat (40) @(posedge clk);
        chk("t3_ferr", n_ferr, 1);
        chk("t3_rises", n_rise, 1);
        send(8'h55, 1'b1, 8, ^8'h55);
        repeat (40) @(posedge clk);
        chk("t3_next_rises", n_rise, 2);
        chk("t3_next_byte", last_byte, 8'h55);

        data_ready = 1'b0;
        send(8'h11, 1'b1, 8, ^8'h11);
        send(8'h22, 1'b1, 8, ^8'h22);
        repeat (40) @(posedge clk);
        #1;
        chk("t4_ovr", n_ovr, 1);
        chk("t4_valid_held", data_valid, 1);
        chk("t4_data_held", data_out, 8'h11);
        data_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("t4_valid_cleared", data_valid, 0);
        chk("t4_rises", n_rise, 3);

        send(8'hFF, 1'b1, 3, 1'b0);
        enable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("t5_busy_off", busy, 0);
        repeat (30) @(posedge clk);
        enable = 1'b1;
        repeat (5) @(posedge clk);
        send(8'h81, 1'b1, 8, ^8'h81);
        repeat (40) @(posedge clk);
        chk("t5_rises", n_rise, 4);
        chk("t5_byte", last_byte, 8'h81);
        chk("t5_ferr", n_ferr, 1);
        chk("t5_ovr", n_ovr, 1);

`ifdef UART_PARITY_EN
        parity_odd = 1'b0;
        send(8'h07, 1'b1, 8, 1'b1);
        repeat (40) @(posedge clk);
        chk("t6_par_ok_rises", n_rise, 5);
        chk("t6_par_ok_byte", last_byte, 8'h07);
        send(8'h07, 1'b1, 8, 1'b0);
        repeat (40) @(posedge clk);
        chk("t6_par_err", n_perr, 1);
        chk("t6_par_bad_rises", n_rise, 5);
`endif

        chk("model_queue_empty", q_exp.size(), 0);
        chk("model_frame_err", n_ferr, exp_ferr);
        chk("model_overrun_err", n_ovr, exp_ovr);
        chk("model_parity_err", n_perr, exp_perr);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
UART receive controller that sequences a bit-period timer to sample a serial line at bit centres.
- Detects the start bit, re-checks it at half-bit, shifts in DATA_W data bits LSB-first, then checks the stop bit.
- Presents each received byte on a valid/ready handshake.
- Sits between the board RX pin and the packet/command logic inside the UART subsystem.

Parameters:
DATA_W, 8, data bits per frame
TIMER_W, 16, width of baud divider and internal bit timer

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-low
enable  input  1  receiver enable; low forces IDLE
baud_div  input  TIMER_W  clocks per bit; values 0..1 treated as 2
rx  input  1  asynchronous serial line, idle high
data_out  output  DATA_W  received byte
data_valid  output  1  data_out holds an unconsumed byte
data_ready  input  1  consumer accepts byte when data_valid&data_ready
busy  output  1  high when state != IDLE
frame_err  output  1  one-cycle pulse, stop bit sampled low
overrun_err  output  1  one-cycle pulse, frame completed while data_valid still high

Behaviour:
- Reset values: data_out=0, data_valid=0, busy=0, frame_err=0, overrun_err=0, sync flops=1, state=IDLE, timer=0.
- rx passes a 2-flop synchronizer; all decisions use its output rx_s.
- Bit timer: counts 0..limit-1 while running, then ticks for one cycle and restarts from 0. Cleared whenever the state changes.
- limit is latched at start detection:
  - half = div>>1 in START;
  - div in DATA/STOP;
  - div = max(baud_div,2).
  - baud_div changes mid-frame have no effect.
- FSM:
  - IDLE: rx_s==0 -> START, latch div.
  - START: at half tick, rx_s==0 -> DATA with bit_cnt=0; rx_s==1 -> IDLE (glitch rejected, no flags).
  - DATA: on each tick, shift rx_s into MSB of shift register (LSB-first). bit_cnt++. After bit DATA_W-1 -> STOP (or PARITY, see Optional Feature).
  - STOP: on tick, rx_s==1 -> frame accepted; rx_s==0 -> frame_err pulse, byte discarded. Then -> IDLE.
- Leaving STOP at mid-stop-bit allows back-to-back frames, since a start edge is detectable immediately.
- Accept, data_valid==0: data_out<=shift, data_valid<=1 next cycle.
- Accept, data_valid==1 and no handshake that cycle: overrun_err pulse, old data_out retained, new byte dropped.
- Accept in the same cycle as a handshake: the new byte loads, data_valid stays 1, no overrun.
- Handshake (data_valid&data_ready) with no accept: data_valid<=0 next cycle.
- frame_err and overrun_err never assert in the same cycle.
- enable low: state->IDLE and timer cleared in the next cycle; any partial frame is discarded silently. data_valid/data_out are unaffected.
- busy is a registered decode of state.

Optional Feature:
Macro UART_PARITY_EN.
- Defined:
  - adds input parity_odd (1=odd, 0=even) and output parity_err (1-bit pulse);
  - adds state PARITY between DATA and STOP, sampled on one tick;
  - a parity mismatch pulses parity_err in the STOP-evaluation cycle and discards the byte;
  - frame_err takes precedence if the stop bit is also bad (only frame_err pulses).
- Undefined: no parity ports or state; frame is start + DATA_W + stop.

Decomposition:
- uart_pkg holds:
  - rx_state_t enum (IDLE, START, DATA, STOP, PARITY);
  - timer_t (logic [TIMER_W-1:0]);
  - TRUE/FALSE constants;
  - MIN_DIV=2.
- Natural sub-module: uart_rx_sync, the 2-flop synchronizer with reset value 1. The bit timer stays inline.

Test Plan:
- baud_div=16, send 0xA5 8N1, data_ready=1:
  - data_out=0xA5, data_valid one cycle, frame_err=0;
  - data_valid rises 152..156 clocks after the rx fall.
- baud_div=16, rx low pulse of 4 clocks then high -> back to IDLE, busy falls, no data_valid, no errors.
- baud_div=16, send 0x3C with stop bit forced 0 -> frame_err single pulse, data_valid stays 0, next clean frame 0x55 received.
- data_ready=0, send 0x11 then 0x22 back-to-back:
  - data_out=0x11 held, overrun_err one pulse at end of 2nd frame;
  - raising data_ready then clears data_valid.
- enable dropped after 3 data bits of 0xFF -> busy=0 within 2 clocks, no flags; re-enable, send 0x81 -> 0x81 received.
- With UART_PARITY_EN, parity_odd=0:
  - send 0x07 with parity bit 1 -> accepted;
  - with parity bit 0 -> parity_err pulse, no data_valid.
